truth_table_scanner: RTL and testbench
======================================

Name: truth_table_scanner

Overview:
- Sequential stimulus driver and response checker for the team's 3-input single-output gate functions; it is the initiator end of the A/B/C -> F interface.
- On start, it steps {a,b,c} through 000..111 and waits a programmable settle time after each step.
- It then samples the function's f_in, assembles an 8-bit truth table, and compares it against an expected table.
- It sits beside the combinational function under test on the lab board/bench and reports pass/fail with a mismatch count.

Parameters:
- SETTLE_CYCLES, 2, idle clock cycles between driving a new input vector and sampling f_in (legal 0..15).
- EXPECTED, 8'h1D, expected truth table; bit i = F for {a,b,c} == i. Default is the team's F = ~((A&B)|(~B&C)).

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle request to begin a scan; honoured only in IDLE
- f_in  input  1  output of the function under test
- a  output  1  stimulus input A (MSB of vector index)
- b  output  1  stimulus input B
- c  output  1  stimulus input C (LSB)
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle pulse when a scan completes
- truth_table  output  8  captured table, bit i = f_in sampled at index i
- match  output  1  truth_table == EXPECTED; registered, updated with done
- mismatch_count  output  4  number of differing bits (0..8)
- first_fail  output  3  lowest mismatching index; valid when mismatch_count != 0

Behaviour:
- Reset (async, rst_n low): state IDLE; a=b=c=0; busy=0; done=0; truth_table=0; match=0; mismatch_count=0; first_fail=0; index and settle counters 0. Reset mid-scan aborts the scan with no done pulse.
- States: IDLE, SETTLE, SAMPLE, FINISH.
- IDLE:
  - start=1 clears truth_table, mismatch_count, first_fail and match.
  - It sets index=0 and {a,b,c}=000, and sets busy=1 on the next edge.
  - Next state is SETTLE, or SAMPLE if SETTLE_CYCLES==0.
- SETTLE: counts SETTLE_CYCLES cycles with the vector held stable, then goes to SAMPLE.
- SAMPLE (one cycle):
  - Captures truth_table[index] <= f_in.
  - If f_in != EXPECTED[index], mismatch_count increments; if it was 0, first_fail <= index.
  - If index==7, go to FINISH. Otherwise index+1 and {a,b,c} update on the same edge, and the next state is SETTLE, or SAMPLE if SETTLE_CYCLES==0.
- FINISH (one cycle): done=1; match=(mismatch_count==0); busy=0 on the following edge; return to IDLE.
- Latency: done asserts 8*(SETTLE_CYCLES+1)+1 cycles after the start-accept edge. This is 25 cycles at the default.
- The index counter is 3 bits but never wraps; termination is by the index==7 check.
- mismatch_count saturates naturally at 8 (4 bits).
- start while busy or in FINISH is ignored and not queued.
- start coincident with rst_n deassertion is ignored: the first accepted start is on an edge where rst_n is high.
- Results hold in IDLE until the next accepted start.
- {a,b,c} are registered outputs, glitch-free, changed only on clk edges.

Optional Feature:
- Macro STOP_ON_MISMATCH_EN.
- Defined: the scan aborts on the SAMPLE cycle of the first mismatch and goes straight to FINISH. mismatch_count=1, first_fail=failing index, match=0, and unsampled truth_table bits remain 0.
- Undefined: the full 8-vector scan always runs and counts all mismatches.

Test Plan:
- Model f_in = ~((a&b)|(~b&c)) with SETTLE_CYCLES=2 and pulse start -> done exactly 25 cycles after accept; truth_table=8'h1D, match=1, mismatch_count=0; a,b,c visit 000..111 in order, each held 3 cycles.
- Tie f_in=0 -> truth_table=8'h00, mismatch_count=4, first_fail=0, match=0 (macro off). With STOP_ON_MISMATCH_EN: done after 4 cycles, mismatch_count=1, first_fail=0.
- Model f_in = ~f (inverted) -> truth_table=8'hE2, mismatch_count=8, first_fail=0, match=0.
- SETTLE_CYCLES=0 with the correct model -> done 9 cycles after accept, truth_table=8'h1D, match=1.
- Pulse start again at cycle 5 of a scan -> ignored; exactly one done pulse, results unchanged from a single scan.
- Drive rst_n low at cycle 10 of a scan -> all outputs return to reset values immediately; no done pulse. A new start afterwards completes normally with 8'h1D.

Source files
------------

// File: rtl/truth_table_scanner.sv
// Truth-table scanner: drives {a,b,c} through 000..111, samples f_in after a settle delay,
// and compares the captured table with EXPECTED. Optional: STOP_ON_MISMATCH_EN aborts on first mismatch.
module truth_table_scanner #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter logic [7:0]  EXPECTED      = 8'h1D
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       f_in,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       busy,
    output logic       done,
    output logic [7:0] truth_table,
    output logic       match,
    output logic [3:0] mismatch_count,
    output logic [2:0] first_fail
);

    localparam int unsigned IDX_W = 3;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned TT_W  = 8;
    localparam bit              NO_SETTLE   = (SETTLE_CYCLES == 0);
    localparam logic [CNT_W-1:0] SETTLE_LAST = NO_SETTLE ? CNT_W'(0) : CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  index_q, index_d;
    logic [CNT_W-1:0]  settle_q, settle_d;
    logic              busy_d, done_d, match_d;
    logic [TT_W-1:0]   tt_d;
    logic [CNT_W-1:0]  mc_d;
    logic [IDX_W-1:0]  ff_d;
    logic              miss;
    logic              last;

    // Stimulus vector comes straight from the index flops, so it only moves on clock edges.
    assign a = index_q[2];
    assign b = index_q[1];
    assign c = index_q[0];

    // State and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            index_q        <= '0;
            settle_q       <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            truth_table    <= '0;
            match          <= 1'b0;
            mismatch_count <= '0;
            first_fail     <= '0;
        end else begin
            state_q        <= state_d;
            index_q        <= index_d;
            settle_q       <= settle_d;
            busy           <= busy_d;
            done           <= done_d;
            truth_table    <= tt_d;
            match          <= match_d;
            mismatch_count <= mc_d;
            first_fail     <= ff_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d  = state_q;
        index_d  = index_q;
        settle_d = settle_q;
        busy_d   = busy;
        done_d   = 1'b0;
        match_d  = match;
        tt_d     = truth_table;
        mc_d     = mismatch_count;
        ff_d     = first_fail;
        miss     = 1'b0;
        last     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    tt_d     = '0;
                    mc_d     = '0;
                    ff_d     = '0;
                    match_d  = 1'b0;
                    index_d  = '0;
                    settle_d = '0;
                    busy_d   = 1'b1;
                    state_d  = NO_SETTLE ? SAMPLE : SETTLE;
                end
            end
            SETTLE: begin
                if (settle_q == SETTLE_LAST) begin
                    settle_d = '0;
                    state_d  = SAMPLE;
                end else begin
                    settle_d = settle_q + CNT_W'(1);
                end
            end
            SAMPLE: begin
                tt_d[index_q] = f_in;
                miss          = (f_in != EXPECTED[index_q]);
                if (miss) begin
                    mc_d = mismatch_count + CNT_W'(1);
                    if (mismatch_count == '0) begin
                        ff_d = index_q;
                    end
                end
`ifdef STOP_ON_MISMATCH_EN
                last = (index_q == IDX_W'(7)) || miss;
`else
                last = (index_q == IDX_W'(7));
`endif
                if (last) begin
                    state_d = FINISH;
                end else begin
                    index_d = index_q + IDX_W'(1);
                    state_d = NO_SETTLE ? SAMPLE : SETTLE;
                end
            end
            FINISH: begin
                done_d  = 1'b1;
                match_d = (mismatch_count == '0);
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_truth_table_scanner.sv
// Randomized self-checking bench for truth_table_scanner; one instance at SETTLE_CYCLES=2,
// one at SETTLE_CYCLES=0, both checked against a table-level reference model.
module tb_truth_table_scanner;

    localparam logic [7:0] EXP_TT = 8'h1D;
    localparam int         BUDGET = 300;

    typedef struct {
        int         lat;
        logic [7:0] tt;
        logic [3:0] mc;
        logic [2:0] ff;
        logic       match;
        int         nvec;
    } res_t;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       sel_z;
    logic [7:0] tbl;

    logic       start_s, f_s, a_s, b_s, c_s, busy_s, done_s, match_s;
    logic [7:0] tt_s;
    logic [3:0] mc_s;
    logic [2:0] ff_s;
    logic       start_z, f_z, a_z, b_z, c_z, busy_z, done_z, match_z;
    logic [7:0] tt_z;
    logic [3:0] mc_z;
    logic [2:0] ff_z;

    logic [2:0] o_abc;
    logic       o_busy, o_done, o_match;
    logic [7:0] o_tt;
    logic [3:0] o_mc;
    logic [2:0] o_ff;

    int total;
    int passed;

    truth_table_scanner #(.SETTLE_CYCLES(2), .EXPECTED(8'h1D)) dut (
        .clk(clk), .rst_n(rst_n), .start(start_s), .f_in(f_s),
        .a(a_s), .b(b_s), .c(c_s), .busy(busy_s), .done(done_s),
        .truth_table(tt_s), .match(match_s), .mismatch_count(mc_s), .first_fail(ff_s)
    );

    truth_table_scanner #(.SETTLE_CYCLES(0), .EXPECTED(8'h1D)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_z), .f_in(f_z),
        .a(a_z), .b(b_z), .c(c_z), .busy(busy_z), .done(done_z),
        .truth_table(tt_z), .match(match_z), .mismatch_count(mc_z), .first_fail(ff_z)
    );

    // The function under test is a lookup into tbl, addressed by the DUT's own stimulus.
    assign f_s     = tbl[{a_s, b_s, c_s}];
    assign f_z     = tbl[{a_z, b_z, c_z}];
    assign start_s = start & ~sel_z;
    assign start_z = start & sel_z;

    assign o_abc   = sel_z ? {a_z, b_z, c_z} : {a_s, b_s, c_s};
    assign o_busy  = sel_z ? busy_z  : busy_s;
    assign o_done  = sel_z ? done_z  : done_s;
    assign o_match = sel_z ? match_z : match_s;
    assign o_tt    = sel_z ? tt_z    : tt_s;
    assign o_mc    = sel_z ? mc_z    : mc_s;
    assign o_ff    = sel_z ? ff_z    : ff_s;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: walk the table in index order, count differing bits, note the first one.
    function automatic res_t model(input logic [7:0] t, input int s);
        res_t m;
        m.tt = '0; m.mc = '0; m.ff = '0; m.nvec = 0;
        for (int i = 0; i < 8; i++) begin
            m.tt[i] = t[i];
            m.nvec++;
            if (t[i] != EXP_TT[i]) begin
                if (m.mc == 0) m.ff = 3'(i);
                m.mc = m.mc + 4'd1;
`ifdef STOP_ON_MISMATCH_EN
                break;
`endif
            end
        end
        m.match = (m.mc == 0);
        m.lat   = m.nvec * (s + 1) + 1;
        return m;
    endfunction

    function automatic logic [7:0] gate_table();
        logic [7:0] t;
        logic       fa, fb, fc;
        for (int i = 0; i < 8; i++) begin
            fa = i[2]; fb = i[1]; fc = i[0];
            t[i] = ~((fa & fb) | (~fb & fc));
        end
        return t;
    endfunction

    // Run one scan on the selected instance and check every result against the model.
    task automatic run_case(input string name, input logic [7:0] t, input logic z, input int inj);
        res_t       m;
        int         s, cyc, lat;
        bit         seq_ok, busy_ok, pulse_ok;
        logic [2:0] hist [0:BUDGET-1];
        logic [7:0] r_tt;
        logic [3:0] r_mc;
        logic [2:0] r_ff;
        logic       r_match;

        sel_z = z;
        tbl   = t;
        s     = z ? 0 : 2;
        m     = model(t, s);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1; cyc = 0; seq_ok = 1'b1; busy_ok = 1'b1; pulse_ok = 1'b1;
        while (lat < 0 && cyc < BUDGET) begin
            hist[cyc] = o_abc;
            if (o_done) begin
                lat = cyc;
                if (o_busy) busy_ok = 1'b0;
            end else begin
                if (!o_busy) busy_ok = 1'b0;
                if (cyc == inj) start = 1'b1;
                @(posedge clk);
                #1 start = 1'b0;
                cyc++;
            end
        end
        for (int k = 0; k < lat - 1; k++)
            if (hist[k] !== 3'(k / (s + 1))) seq_ok = 1'b0;
        r_tt = o_tt; r_mc = o_mc; r_ff = o_ff; r_match = o_match;
        repeat (3) begin
            @(posedge clk);
            #1 if (o_done || o_busy) pulse_ok = 1'b0;
        end

        total++; if (lat !== m.lat) $display("FAIL %s latency: got %0d want %0d", name, lat, m.lat); else passed++;
        total++; if (r_tt !== m.tt) $display("FAIL %s truth_table: got %h want %h", name, r_tt, m.tt); else passed++;
        total++; if (r_mc !== m.mc) $display("FAIL %s mismatch_count: got %0d want %0d", name, r_mc, m.mc); else passed++;
        total++; if (r_ff !== m.ff) $display("FAIL %s first_fail: got %0d want %0d", name, r_ff, m.ff); else passed++;
        total++; if (r_match !== m.match) $display("FAIL %s match: got %b want %b", name, r_match, m.match); else passed++;
        total++; if (seq_ok !== 1'b1) $display("FAIL %s abc_sequence: got out-of-order/held-wrong want 000..111 stepped every %0d cycles", name, s + 1); else passed++;
        total++; if (busy_ok !== 1'b1) $display("FAIL %s busy_window: got wrong busy level want high until done", name); else passed++;
        total++; if (pulse_ok !== 1'b1) $display("FAIL %s done_pulse: got done/busy after pulse want single pulse then idle", name); else passed++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; sel_z = 1'b0; tbl = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({a_s, b_s, c_s, busy_s, done_s, tt_s, match_s, mc_s, ff_s} !== '0)
            $display("FAIL reset_s2: got %b want all zero", {a_s, b_s, c_s, busy_s, done_s, tt_s, match_s, mc_s, ff_s});
        else passed++;
        total++;
        if ({a_z, b_z, c_z, busy_z, done_z, tt_z, match_z, mc_z, ff_z} !== '0)
            $display("FAIL reset_s0: got %b want all zero", {a_z, b_z, c_z, busy_z, done_z, tt_z, match_z, mc_z, ff_z});
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_correct();
        run_case("correct", gate_table(), 1'b0, -1);
    endtask

    task automatic test_tied_low();
        run_case("tied_low", 8'h00, 1'b0, -1);
    endtask

    task automatic test_inverted();
        run_case("inverted", ~gate_table(), 1'b0, -1);
    endtask

    task automatic test_zero_settle();
        run_case("zero_settle", gate_table(), 1'b1, -1);
        run_case("zero_settle_inv", ~gate_table(), 1'b1, -1);
    endtask

    task automatic test_restart_ignored();
        run_case("restart_ignored", gate_table(), 1'b0, 5);
    endtask

    task automatic test_random();
        logic [7:0] t;
        for (int n = 0; n < 6; n++) begin
            t = 8'($urandom);
            run_case($sformatf("random%0d", n), t, 1'($urandom_range(0, 1)), int'($urandom_range(1, 6)));
        end
    endtask

    task automatic test_reset_mid_scan();
        bit seen;
        sel_z = 1'b0;
        tbl   = gate_table();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        total++;
        if ({a_s, b_s, c_s, busy_s, done_s, tt_s, match_s, mc_s, ff_s} !== '0)
            $display("FAIL mid_reset_outputs: got %b want all zero", {a_s, b_s, c_s, busy_s, done_s, tt_s, match_s, mc_s, ff_s});
        else passed++;
        seen = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1 if (done_s) seen = 1'b1;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) begin
            @(posedge clk);
            #1 if (done_s || busy_s) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) $display("FAIL mid_reset_no_done: got done/busy activity %b want 0", seen);
        else passed++;
        run_case("after_reset", gate_table(), 1'b0, -1);
    endtask

    initial begin
        total  = 0;
        passed = 0;
        test_reset();
        test_correct();
        test_tied_low();
        test_inverted();
        test_zero_settle();
        test_restart_ignored();
        test_random();
        test_reset_mid_scan();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
